// File: rtl/seg_display_scheduler.sv
// Time-multiplexed 4-digit common-anode 7-segment driver with inter-digit blanking,
// frame-aligned value updates through a single-entry valid/ready pending register.
module seg_display_scheduler #(
    parameter int TICK_DIV  = 100000,
    parameter int BLANK_CYC = 1000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] val_in,
    input  logic [3:0]  dp_in,
    input  logic        lz_en,
    input  logic        val_valid,
    output logic        val_ready,
    output logic        frame_done,
    output logic [6:0]  seg,
    output logic        dp,
    output logic [3:0]  an
);

    localparam int MAX_CYC = (TICK_DIV > BLANK_CYC) ? TICK_DIV : BLANK_CYC;
    localparam int CNT_W   = (MAX_CYC > 1) ? $clog2(MAX_CYC) : 1;

    localparam logic [CNT_W-1:0] TICK_LAST  = CNT_W'(TICK_DIV - 1);
    localparam logic [CNT_W-1:0] BLANK_LAST = CNT_W'(BLANK_CYC - 1);

    localparam logic [0:0] ST_BLANK = 1'b0;
    localparam logic [0:0] ST_DRIVE = 1'b1;

    logic [0:0]       state;
    logic [1:0]       idx;
    logic [CNT_W-1:0] cnt;

    logic [15:0] shadow_val;
    logic [3:0]  shadow_dp;
    logic [15:0] pend_val;
    logic [3:0]  pend_dp;
    logic        pend_full;

    logic        cnt_last;
    logic        boundary;
    logic [3:0]  cur_nib;
    logic [3:0]  zero_from;
    logic        suppress;
    logic [6:0]  seg_nxt;
    logic        dp_nxt;
    logic [3:0]  an_nxt;

    function automatic logic [6:0] hex_decode(input logic [3:0] nib);
        logic [6:0] s;
        case (nib)
            4'h0: s = 7'b1000000;
            4'h1: s = 7'b1111001;
            4'h2: s = 7'b0100100;
            4'h3: s = 7'b0110000;
            4'h4: s = 7'b0011001;
            4'h5: s = 7'b0010010;
            4'h6: s = 7'b0000010;
            4'h7: s = 7'b1111000;
            4'h8: s = 7'b0000000;
            4'h9: s = 7'b0010000;
            4'hA: s = 7'b0001000;
            4'hB: s = 7'b0000011;
            4'hC: s = 7'b1000110;
            4'hD: s = 7'b0100001;
            4'hE: s = 7'b0000110;
            default: s = 7'b0001110;
        endcase
        return s;
    endfunction

    assign val_ready = !pend_full;
    assign cnt_last  = (state == ST_BLANK) ? (cnt == BLANK_LAST) : (cnt == TICK_LAST);
    assign boundary  = (state == ST_DRIVE) && (idx == 2'd3) && cnt_last;

    assign cur_nib = shadow_val[{idx, 2'b00} +: 4];

    // zero_from[i]: nibbles i..3 of the shadow value are all zero
    assign zero_from[3] = (shadow_val[15:12] == 4'h0);
    assign zero_from[2] = zero_from[3] && (shadow_val[11:8] == 4'h0);
    assign zero_from[1] = zero_from[2] && (shadow_val[7:4] == 4'h0);
    assign zero_from[0] = zero_from[1] && (shadow_val[3:0] == 4'h0);

    assign suppress = lz_en && (idx != 2'd0) && zero_from[idx];

    always_comb begin
        // NOTE: every output of this block gets a default first, so no path can infer a latch.
        an_nxt  = 4'b1111;
        seg_nxt = 7'b1111111;
        dp_nxt  = 1'b1;
        if (state == ST_DRIVE) begin
            an_nxt  = ~(4'b0001 << idx);
            dp_nxt  = ~shadow_dp[idx];
            seg_nxt = suppress ? 7'b1111111 : hex_decode(cur_nib);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= ST_BLANK;
            idx   <= 2'd0;
            cnt   <= '0;
        end else if (cnt_last) begin
            // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
            cnt   <= '0;
            state <= ~state;
            if (state == ST_DRIVE) begin
                idx <= idx + 2'd1;
            end
        end else begin
            cnt <= cnt + 1'b1;
        end
    end

    // A value accepted on the boundary cycle waits for the next boundary, since pend_full was still 0.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            shadow_val <= 16'h0000;
            shadow_dp  <= 4'b0000;
            pend_val   <= 16'h0000;
            pend_dp    <= 4'b0000;
            pend_full  <= 1'b0;
        end else if (boundary && pend_full) begin
            shadow_val <= pend_val;
            shadow_dp  <= pend_dp;
            pend_full  <= 1'b0;
        end else if (val_valid && !pend_full) begin
            pend_val  <= val_in;
            pend_dp   <= dp_in;
            pend_full <= 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            an         <= 4'b1111;
            seg        <= 7'b1111111;
            dp         <= 1'b1;
            frame_done <= 1'b0;
        end else begin
            an         <= an_nxt;
            seg        <= seg_nxt;
            dp         <= dp_nxt;
            frame_done <= boundary;
        end
    end

endmodule

// File: tb/tb_seg_display_scheduler.sv
// Directed bench for seg_display_scheduler with TICK_DIV=4, BLANK_CYC=2 (24-cycle frames);
// cycle k is observed 1 time unit after the k-th rising edge following reset release.
module tb_seg_display_scheduler;

    logic        clk;
    logic        rst;
    logic [15:0] val_in;
    logic [3:0]  dp_in;
    logic        lz_en;
    logic        val_valid;
    logic        val_ready;
    logic        frame_done;
    logic [6:0]  seg;
    logic        dp;
    logic [3:0]  an;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;

    localparam logic [6:0] S_OFF = 7'b1111111;
    localparam logic [6:0] S_0   = 7'b1000000;
    localparam logic [6:0] S_1   = 7'b1111001;
    localparam logic [6:0] S_2   = 7'b0100100;
    localparam logic [6:0] S_5   = 7'b0010010;
    localparam logic [6:0] S_A   = 7'b0001000;
    localparam logic [6:0] S_F   = 7'b0001110;

    seg_display_scheduler #(.TICK_DIV(4), .BLANK_CYC(2)) dut (
        .clk        (clk),
        .rst        (rst),
        .val_in     (val_in),
        .dp_in      (dp_in),
        .lz_en      (lz_en),
        .val_valid  (val_valid),
        .val_ready  (val_ready),
        .frame_done (frame_done),
        .seg        (seg),
        .dp         (dp),
        .an         (an)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s @cyc %0d: got %h expected %h", tag, cyc, got, exp);
        end
    endtask

    task automatic check_out(input string tag, input logic [3:0] e_an, input logic [6:0] e_seg,
                             input logic e_dp);
        check({tag, ".an"},  16'(an),  16'(e_an));
        check({tag, ".seg"}, 16'(seg), 16'(e_seg));
        check({tag, ".dp"},  16'(dp),  16'(e_dp));
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic run_to(input int n);
        while (cyc < n) tick();
    endtask

    task automatic do_reset();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        cyc = 0;
    endtask

    initial begin
        val_in    = 16'h0000;
        dp_in     = 4'b0000;
        lz_en     = 1'b0;
        val_valid = 1'b0;
        rst       = 1'b1;
        #2;
        check_out("rst_out", 4'b1111, S_OFF, 1'b1);
        check("rst_fd", 16'(frame_done), 16'd0);
        check("rst_rdy", 16'(val_ready), 16'd1);
        do_reset();

        // Frame 1: zeros, slot timing
        run_to(1);  check_out("c1_blank", 4'b1111, S_OFF, 1'b1);
        run_to(2);  check_out("c2_blank", 4'b1111, S_OFF, 1'b1);
        run_to(3);  check_out("c3_d0", 4'b1110, S_0, 1'b1);
        run_to(6);  check_out("c6_d0", 4'b1110, S_0, 1'b1);
        run_to(7);  check_out("c7_blank", 4'b1111, S_OFF, 1'b1);
        run_to(8);  check_out("c8_blank", 4'b1111, S_OFF, 1'b1);
        run_to(9);  check_out("c9_d1", 4'b1101, S_0, 1'b1);
        run_to(21); check_out("c21_d3", 4'b0111, S_0, 1'b1);
        run_to(23); check("fd_c23", 16'(frame_done), 16'd0);
        run_to(24); check("fd_c24", 16'(frame_done), 16'd1);
        run_to(25); check("fd_c25", 16'(frame_done), 16'd0);

        // Mid-frame load of 12AF, then a dropped second value
        run_to(30);
        check("rdy_pre_load", 16'(val_ready), 16'd1);
        val_in = 16'h12AF; dp_in = 4'b0100; val_valid = 1'b1;
        run_to(31);
        val_valid = 1'b0;
        check("rdy_pending", 16'(val_ready), 16'd0);
        run_to(39); check_out("f2_d2_old", 4'b1011, S_0, 1'b1);
        run_to(40);
        val_in = 16'h3333; dp_in = 4'b1111; val_valid = 1'b1;
        run_to(41);
        val_valid = 1'b0;
        check("rdy_drop", 16'(val_ready), 16'd0);
        run_to(47); check("rdy_c47", 16'(val_ready), 16'd0);
        run_to(48);
        check("fd_c48", 16'(frame_done), 16'd1);
        check("rdy_c48", 16'(val_ready), 16'd1);

        // Frame 3: 12AF with dp on digit 2
        run_to(51); check_out("f3_d0", 4'b1110, S_F, 1'b1);
        run_to(55); check_out("f3_blank", 4'b1111, S_OFF, 1'b1);
        run_to(57); check_out("f3_d1", 4'b1101, S_A, 1'b1);
        run_to(63); check_out("f3_d2", 4'b1011, S_2, 1'b0);
        run_to(69); check_out("f3_d3", 4'b0111, S_1, 1'b1);

        // Accept 0005 on the boundary cycle (cycle 71): shown only from frame 5
        run_to(71);
        val_in = 16'h0005; dp_in = 4'b0000; val_valid = 1'b1;
        run_to(72);
        val_valid = 1'b0;
        check("fd_c72", 16'(frame_done), 16'd1);
        check("rdy_c72", 16'(val_ready), 16'd0);
        run_to(75); check_out("f4_d0_hold", 4'b1110, S_F, 1'b1);
        run_to(96);
        check("fd_c96", 16'(frame_done), 16'd1);
        check("rdy_c96", 16'(val_ready), 16'd1);
        lz_en = 1'b1;

        // Frame 5: 0005 with leading-zero suppression
        run_to(99);  check_out("lz5_d0", 4'b1110, S_5, 1'b1);
        run_to(100);
        val_in = 16'h0000; dp_in = 4'b0000; val_valid = 1'b1;
        run_to(101);
        val_valid = 1'b0;
        run_to(105); check_out("lz5_d1", 4'b1101, S_OFF, 1'b1);
        run_to(111); check_out("lz5_d2", 4'b1011, S_OFF, 1'b1);
        run_to(117); check_out("lz5_d3", 4'b0111, S_OFF, 1'b1);

        // Frame 6: 0000; digit 0 never suppressed, lz_en dropped live
        run_to(123); check_out("lz0_d0", 4'b1110, S_0, 1'b1);
        run_to(129); check_out("lz0_d1", 4'b1101, S_OFF, 1'b1);
        run_to(130);
        lz_en = 1'b0;
        run_to(135); check_out("nolz_d2", 4'b1011, S_0, 1'b1);

        // Frame 7: pending 9876, reset during DRIVE of digit 2
        run_to(146);
        val_in = 16'h9876; dp_in = 4'b1111; val_valid = 1'b1;
        run_to(147);
        val_valid = 1'b0;
        check("rdy_pend2", 16'(val_ready), 16'd0);
        run_to(160);
        check("pre_rst_an", 16'(an), 16'(4'b1011));
        rst = 1'b1;
        #1;
        check_out("async_rst", 4'b1111, S_OFF, 1'b1);
        check("async_rst_rdy", 16'(val_ready), 16'd1);
        check("async_rst_fd", 16'(frame_done), 16'd0);
        do_reset();
        run_to(2);  check_out("r_c2_blank", 4'b1111, S_OFF, 1'b1);
        run_to(3);  check_out("r_c3_d0", 4'b1110, S_0, 1'b1);
        run_to(21); check_out("r_c21_d3", 4'b0111, S_0, 1'b1);
        run_to(24);
        check("r_fd_c24", 16'(frame_done), 16'd1);
        check("r_rdy_c24", 16'(val_ready), 16'd1);
        run_to(27); check_out("r_f2_d0", 4'b1110, S_0, 1'b1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
